// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module : stopwatch_pkg
// Brief  : Shared state encoding and constants for the stopwatch controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package stopwatch_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    ADJ  = 2'd2
  } state_t;

  localparam logic SEL_SEC = 1'b0;
  localparam logic SEL_MIN = 1'b1;

  localparam int unsigned BLINK_W = 4;

  // Leaving ADJ either drops to STOP or resumes the run/stop state saved on entry.
  function automatic state_t adj_exit_state(input logic resume, input state_t saved);
    return resume ? saved : STOP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
// ============================================================================
// Module : stopwatch_ctrl_if
// Brief  : Button/switch/tick inputs and command/blank outputs of the controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface stopwatch_ctrl_if;

  logic btn_pause;
  logic btn_reset;
  logic btn_lap;
  logic sw_adj;
  logic sw_sel;
  logic tick_1hz;
  logic tick_2hz;
  logic tick_blink;

  logic cnt_en;
  logic cnt_clr;
  logic adj_sec_inc;
  logic adj_min_inc;
  logic blank_sec;
  logic blank_min;
  logic running;
  logic disp_hold;

  modport master (
    output btn_pause, btn_reset, btn_lap, sw_adj, sw_sel,
    output tick_1hz, tick_2hz, tick_blink,
    input  cnt_en, cnt_clr, adj_sec_inc, adj_min_inc,
    input  blank_sec, blank_min, running, disp_hold
  );

  modport slave (
    input  btn_pause, btn_reset, btn_lap, sw_adj, sw_sel,
    input  tick_1hz, tick_2hz, tick_blink,
    output cnt_en, cnt_clr, adj_sec_inc, adj_min_inc,
    output blank_sec, blank_min, running, disp_hold
  );

endinterface

`default_nettype wire

// File: rtl/rise_edge.sv
// ============================================================================
// Module : rise_edge
// Brief  : Registered single-cycle pulse on each rising edge of a level input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_pulse
);

  logic r_prev;
  logic r_pulse;

  // History clears to 0 so a level already high at reset release yields one pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= i_d;
      r_pulse <= i_d & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module : stopwatch_ctrl
// Brief  : STOP/RUN/ADJ sequencer issuing counter commands and digit blanking.
//          Optional lap/display-hold feature built when STOPWATCH_LAP_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned BLINK_DIV    = 1,
  parameter int unsigned RESUME_STATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  ctl
);

  localparam logic [BLINK_W-1:0] c_blink_last = BLINK_W'(BLINK_DIV - 1);
  localparam logic               c_resume     = (RESUME_STATE != 0);

  logic w_pause_edge;
  logic w_reset_edge;
  logic w_lap_edge;

  state_t             r_state;
  state_t             w_state_nx;
  state_t             r_saved;
  state_t             w_saved_nx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [BLINK_W-1:0] w_blink_cnt_nx;
  logic               r_phase;
  logic               w_phase_nx;

  logic w_cnt_en_nx;
  logic w_sec_inc_nx;
  logic w_min_inc_nx;
  logic w_blank_sec_nx;
  logic w_blank_min_nx;

  logic r_cnt_en;
  logic r_cnt_clr;
  logic r_adj_sec_inc;
  logic r_adj_min_inc;
  logic r_blank_sec;
  logic r_blank_min;
  logic r_running;

  rise_edge u_pause_edge (
    .clk     (clk),
    .rst     (rst),
    .i_d     (ctl.btn_pause),
    .o_pulse (w_pause_edge)
  );

  rise_edge u_reset_edge (
    .clk     (clk),
    .rst     (rst),
    .i_d     (ctl.btn_reset),
    .o_pulse (w_reset_edge)
  );

  rise_edge u_lap_edge (
    .clk     (clk),
    .rst     (rst),
    .i_d     (ctl.btn_lap),
    .o_pulse (w_lap_edge)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= STOP;
      r_saved     <= STOP;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_saved     <= w_saved_nx;
      r_blink_cnt <= w_blink_cnt_nx;
      r_phase     <= w_phase_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_saved_nx     = r_saved;
    w_blink_cnt_nx = r_blink_cnt;
    w_phase_nx     = r_phase;
    w_cnt_en_nx    = 1'b0;
    w_sec_inc_nx   = 1'b0;
    w_min_inc_nx   = 1'b0;

    case (r_state)
      STOP, RUN: begin
        // The adjust switch outranks a pause edge; a reset edge swallows the pause edge.
        if (ctl.sw_adj) begin
          w_state_nx = ADJ;
          w_saved_nx = r_state;
        end else if (w_pause_edge && !w_reset_edge) begin
          w_state_nx = (r_state == RUN) ? STOP : RUN;
        end
        if ((r_state == RUN) && ctl.tick_1hz && !w_reset_edge) begin
          w_cnt_en_nx = 1'b1;
        end
      end
      ADJ: begin
        if (!ctl.sw_adj) begin
          w_state_nx = adj_exit_state(c_resume, r_saved);
        end
        if (ctl.tick_2hz && !w_reset_edge) begin
          if (ctl.sw_sel == SEL_MIN) begin
            w_min_inc_nx = 1'b1;
          end else begin
            w_sec_inc_nx = 1'b1;
          end
        end
        if (ctl.tick_blink) begin
          if (r_blink_cnt == c_blink_last) begin
            w_blink_cnt_nx = '0;
            w_phase_nx     = ~r_phase;
          end else begin
            w_blink_cnt_nx = r_blink_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = STOP;
      end
    endcase

    // Blink machinery idles at zero whenever the next state is not ADJ.
    if (w_state_nx != ADJ) begin
      w_blink_cnt_nx = '0;
      w_phase_nx     = 1'b0;
    end

    w_blank_sec_nx = w_phase_nx && (ctl.sw_sel == SEL_SEC);
    w_blank_min_nx = w_phase_nx && (ctl.sw_sel == SEL_MIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_en      <= 1'b0;
      r_cnt_clr     <= 1'b0;
      r_adj_sec_inc <= 1'b0;
      r_adj_min_inc <= 1'b0;
      r_blank_sec   <= 1'b0;
      r_blank_min   <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      r_cnt_en      <= w_cnt_en_nx;
      r_cnt_clr     <= w_reset_edge;
      r_adj_sec_inc <= w_sec_inc_nx;
      r_adj_min_inc <= w_min_inc_nx;
      r_blank_sec   <= w_blank_sec_nx;
      r_blank_min   <= w_blank_min_nx;
      r_running     <= (w_state_nx == RUN);
    end
  end

  assign ctl.cnt_en      = r_cnt_en;
  assign ctl.cnt_clr     = r_cnt_clr;
  assign ctl.adj_sec_inc = r_adj_sec_inc;
  assign ctl.adj_min_inc = r_adj_min_inc;
  assign ctl.blank_sec   = r_blank_sec;
  assign ctl.blank_min   = r_blank_min;
  assign ctl.running     = r_running;

`ifdef STOPWATCH_LAP_EN
  logic r_disp_hold;

  // Hold toggles on lap only while staying in RUN; reset edge or leaving RUN releases it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp_hold <= 1'b0;
    end else if ((w_state_nx != RUN) || w_reset_edge) begin
      r_disp_hold <= 1'b0;
    end else if ((r_state == RUN) && w_lap_edge) begin
      r_disp_hold <= ~r_disp_hold;
    end
  end

  assign ctl.disp_hold = r_disp_hold;
`else
  logic w_lap_unused;

  assign w_lap_unused  = w_lap_edge;
  assign ctl.disp_hold = 1'b0;
`endif

  a_clr_exclusive: assert property (@(posedge clk) disable iff (!rst)
    r_cnt_clr |-> !(r_cnt_en || r_adj_sec_inc || r_adj_min_inc));

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the stopwatch MM:SS counter datapath.
- Turns debounced button levels, adjust switches and clock-enable strobes from the clock generator into single-cycle increment, clear and adjust commands, plus digit-blank controls for the seven-segment driver.
- Sits between the debouncers/clock generator and the BCD counter/display.
- The counter itself is not in this block.

Parameters:
- BLINK_DIV, 1: number of tick_blink strobes per blink-phase toggle (1..15).
- RESUME_STATE, 0: state on leaving ADJ. 0 = always STOP; 1 = the run/stop state held when ADJ was entered.

Ports:
- clk  in  1  system clock; all other inputs synchronous to it.
- rst  in  1  asynchronous, active-low reset.
- btn_pause  in  1  debounced pause button level.
- btn_reset  in  1  debounced reset button level.
- btn_lap  in  1  debounced lap button level; used only with STOPWATCH_LAP_EN.
- sw_adj  in  1  adjust-mode switch level.
- sw_sel  in  1  adjust field select: 0 = seconds, 1 = minutes.
- tick_1hz  in  1  one-cycle enable strobe at 1 Hz.
- tick_2hz  in  1  one-cycle enable strobe at 2 Hz.
- tick_blink  in  1  one-cycle enable strobe for blinking.
- cnt_en  out  1  one-cycle pulse: advance the timer by one second.
- cnt_clr  out  1  one-cycle pulse: clear the timer to 00:00.
- adj_sec_inc  out  1  one-cycle pulse: increment the seconds field only, mod 60, no carry.
- adj_min_inc  out  1  one-cycle pulse: increment the minutes field only, mod 100.
- blank_sec  out  1  blank the seconds digits.
- blank_min  out  1  blank the minutes digits.
- running  out  1  high when state == RUN.
- disp_hold  out  1  display freeze (lap) request.

Behaviour:
- Reset (rst low, asynchronous):
  - State = STOP, all outputs 0, blink phase 0, blink divider 0.
  - Edge-detect history registers load 0, so a button already held at reset release produces one edge.
- Edge detection: rising edge of each btn_* is registered; the internal edge pulse is valid in the cycle after the level rises.
- Outputs are registered: command pulses appear 1 clk after the causing tick or edge.
- States: STOP, RUN, ADJ.
  - STOP → RUN on pause edge.
  - RUN → STOP on pause edge.
  - STOP/RUN → ADJ whenever sw_adj = 1; this has priority over a same-cycle pause edge.
  - ADJ → STOP, or the saved state if RESUME_STATE = 1, when sw_adj = 0.
  - Pause edges are ignored in ADJ.
- RUN: tick_1hz → cnt_en next cycle. No prescaler phase reset on resume; the first cnt_en follows the next tick_1hz after entering RUN.
- Reset edge, any state:
  - cnt_clr pulses next cycle.
  - State is unchanged: RUN continues counting from 00:00.
- Simultaneous events:
  - Reset edge + tick in the same cycle: cnt_clr only; cnt_en and adj_*_inc are suppressed.
  - Reset edge + pause edge: reset is serviced, the pause edge is dropped.
- ADJ:
  - tick_2hz → adj_sec_inc (sw_sel = 0) or adj_min_inc (sw_sel = 1) next cycle.
  - tick_1hz is ignored; cnt_en = 0.
  - sw_sel changes take effect on the next tick.
- Blink:
  - Divider counts tick_blink strobes. At BLINK_DIV it wraps to 0 and toggles the phase.
  - In ADJ: blank of the selected field = phase; the other field's blank = 0.
  - Outside ADJ: both blanks = 0, phase and divider held at 0.
- Reset mid-ADJ (rst low): returns to STOP even if sw_adj = 1. ADJ is re-entered on the first cycle after release.
- running is registered and matches the state one cycle after the transition.

Optional Feature:
- STOPWATCH_LAP_EN defined:
  - In RUN, a lap edge toggles disp_hold; counting continues.
  - disp_hold clears on a reset edge and on leaving RUN.
  - Lap edges outside RUN are ignored.
- Not defined: btn_lap is ignored and disp_hold is tied to 0.

Decomposition:
- Package stopwatch_pkg holds:
  - the state enum (STOP = 2'd0, RUN = 2'd1, ADJ = 2'd2);
  - the field-select constants SEL_SEC = 1'b0 and SEL_MIN = 1'b1;
  - the blink divider width constant (4).
- Sub-module rise_edge: 1-bit registered rising-edge pulse with asynchronous active-low reset. Instantiated three times (pause, reset, lap).

Test Plan:
- Run: release rst, pulse btn_pause high 3 cycles, apply 5 tick_1hz strobes → running = 1 from cycle 2 after the rise; exactly 5 cnt_en pulses, each 1 clk after its tick.
- Reset priority: in RUN, btn_reset edge coincident with a tick_1hz → one cnt_clr, no cnt_en that cycle; running stays 1; the next tick gives cnt_en.
- Adjust: sw_adj = 1, sw_sel = 1, 4 tick_2hz strobes → 4 adj_min_inc pulses, 0 adj_sec_inc, 0 cnt_en. With BLINK_DIV = 1, blank_min toggles on every tick_blink and blank_sec = 0.
- ADJ exit: RESUME_STATE = 1, enter ADJ from RUN, then sw_adj = 0 → returns to RUN (running = 1). Repeat with RESUME_STATE = 0 → STOP.
- Async reset: assert rst low mid-cycle during ADJ with blink phase 1 → all outputs 0 immediately, no clock needed; with sw_adj still 1, ADJ re-entered after release.
- Lap (STOPWATCH_LAP_EN): in RUN, lap edge → disp_hold = 1 and cnt_en continues; pause edge → STOP and disp_hold = 0. Without the macro, disp_hold stays 0 throughout.
